decode_operand_stage: RTL

Parametrised decode-stage operand block: it holds the integer register file with NUM_WR_PORTS writeback ports. It reads rs1/rs2 for the incoming instruction, with same-cycle write bypass and external forwarding override, and registers the result into a valid/ready output pipeline register with flush. It sits between fetch and execute and is the multi-port, handshaked successor of the single-writeback decode input path.

---
 rtl/decode_operand_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/decode_operand_stage.sv
// Decode operand stage: multi-port integer register file, rs1/rs2 read with forwarding and
// same-cycle write bypass, registered into a 1-cycle valid/ready output register with flush.
module decode_operand_stage #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_WR_PORTS = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    instruction,
    input  logic [XLEN-1:0]                pc,
    input  logic                           compflg,
    input  logic                           fwd_en1,
    input  logic [XLEN-1:0]                fwd_data1,
    input  logic                           fwd_en2,
    input  logic [XLEN-1:0]                fwd_data2,
    input  logic [NUM_WR_PORTS-1:0]        write_en,
    input  logic [5*NUM_WR_PORTS-1:0]      write_id,
    input  logic [XLEN*NUM_WR_PORTS-1:0]   write_data,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_instruction,
    output logic [XLEN-1:0]                out_pc,
    output logic [XLEN-1:0]                out_pc_next,
    output logic                           out_compflg,
    output logic [XLEN-1:0]                out_rs1_data,
    output logic [XLEN-1:0]                out_rs2_data
);

    localparam int IDW = $clog2(NUM_REGS);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_next_q, pc_next_d;
    logic            compflg_q, compflg_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;

    logic [4:0]      rs1_idx, rs2_idx;
    logic [XLEN-1:0] rs1_rf, rs2_rf;
    logic            capture;

    function automatic logic id_ok(input logic [4:0] id);
        return (id != 5'd0) && (32'(id) < 32'(NUM_REGS));
    endfunction

    // Ports scanned in ascending order so the highest-index match is the one left standing.
    function automatic logic [XLEN-1:0] pick_operand(
        input logic [4:0]                 rs,
        input logic                       fe,
        input logic [XLEN-1:0]            fd,
        input logic [XLEN-1:0]            rf_val,
        input logic [NUM_WR_PORTS-1:0]    we,
        input logic [5*NUM_WR_PORTS-1:0]  wid,
        input logic [XLEN*NUM_WR_PORTS-1:0] wdat
    );
        logic [XLEN-1:0] v;
        v = rf_val;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (we[p] && (wid[5*p +: 5] == rs)) begin
                v = wdat[XLEN*p +: XLEN];
            end
        end
        if (fe) begin
            v = fd;
        end
        if (!id_ok(rs)) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (write_en[p] && id_ok(write_id[5*p +: 5])) begin
                regs_d[write_id[5*p +: IDW]] = write_data[XLEN*p +: XLEN];
            end
        end
    end

    assign rs1_idx  = instruction[19:15];
    assign rs2_idx  = instruction[24:20];
    assign rs1_rf   = regs_q[rs1_idx[IDW-1:0]];
    assign rs2_rf   = regs_q[rs2_idx[IDW-1:0]];

    assign in_ready = !flush && (!valid_q || out_ready);
    assign capture  = in_valid && in_ready;

    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        compflg_d = compflg_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d   = 1'b1;
            instr_d   = instruction;
            pc_d      = pc;
            pc_next_d = pc + (compflg ? XLEN'(2) : XLEN'(4));
            compflg_d = compflg;
            rs1_d     = pick_operand(rs1_idx, fwd_en1, fwd_data1, rs1_rf,
                                     write_en, write_id, write_data);
            rs2_d     = pick_operand(rs2_idx, fwd_en2, fwd_data2, rs2_rf,
                                     write_en, write_id, write_data);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            valid_q   <= 1'b0;
            instr_q   <= '0;
            pc_q      <= '0;
            pc_next_q <= '0;
            compflg_q <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
        end else begin
            regs_q    <= regs_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pc_next_q <= pc_next_d;
            compflg_q <= compflg_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_instruction = instr_q;
    assign out_pc          = pc_q;
    assign out_pc_next     = pc_next_q;
    assign out_compflg     = compflg_q;
    assign out_rs1_data    = rs1_q;
    assign out_rs2_data    = rs2_q;

endmodule
